// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: drain FSM states and default depth.
package uart_pkg;

    localparam int DEFAULT_TXQ_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte FIFO for the UART transmit queue: storage, wrapping pointers and occupancy count.
// Pushes while full are dropped; full is decoded from the pre-edge count.
module uart_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                   DEPTH    = 1 << DEPTH_LOG2;
    localparam int                   CNT_W    = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]     FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == CNT_ZERO);
    assign count     = count_r;
    assign head      = mem[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage write; contents are never reset, validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_txq.sv
// UART transmit queue: byte FIFO drained by an IDLE/LAUNCH/HOLD FSM into a downstream transmitter.
// Optional sticky overflow flag (ovf/ovf_clr) is built only when UART_TXQ_OVF_EN is defined.
module uart_txq
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_TXQ_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  uart_wr,
    output logic [7:0]            uart_dat,
    input  logic                  uart_busy
`ifdef UART_TXQ_OVF_EN
    ,
    output logic                  ovf,
    input  logic                  ovf_clr
`endif
);

    drain_state_t state_r;
    logic         uart_wr_r;
    logic [7:0]   uart_dat_r;
    logic [7:0]   head_s;
    logic         pop_s;

    // The byte leaves the FIFO in the same cycle it is presented with uart_wr
    assign pop_s    = (state_r == LAUNCH);
    assign uart_wr  = uart_wr_r;
    assign uart_dat = uart_dat_r;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr),
        .din   (tx_data),
        .pop   (pop_s),
        .head  (head_s),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Drain FSM; HOLD spends one cycle so the transmitter's busy has time to rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            uart_wr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty && !uart_busy) begin
                        state_r   <= LAUNCH;
                        uart_wr_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        uart_wr_r <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state_r   <= HOLD;
                    uart_wr_r <= 1'b0;
                end
                HOLD: begin
                    state_r   <= IDLE;
                    uart_wr_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    uart_wr_r <= 1'b0;
                end
            endcase
        end
    end

    // Output byte tracks the head; the head cannot move before LAUNCH, so it is valid with uart_wr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_dat_r <= 8'h00;
        end else begin
            uart_dat_r <= head_s;
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_r;
    logic drop_s;

    assign drop_s = wr & full;
    assign ovf    = ovf_r;

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`endif

endmodule

// File: tb/tb_uart_txq.sv
// Directed self-checking bench for uart_txq (depth 16); ovf checks compiled in with UART_TXQ_OVF_EN.
`timescale 1ns/1ps
module tb_uart_txq;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       uart_wr;
    logic [7:0] uart_dat;
    logic       uart_busy;
    logic       busy_man;
    logic       auto_busy;
`ifdef UART_TXQ_OVF_EN
    logic       ovf;
    logic       ovf_clr;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int consec_err = 0;
    int busy_err = 0;
    logic prev_wr = 1'b0;
    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] in_q[$];

    uart_txq #(.DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .uart_wr   (uart_wr),
        .uart_dat  (uart_dat),
        .uart_busy (uart_busy)
`ifdef UART_TXQ_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    assign uart_busy = busy_man | (busy_cnt != 0);

    // Output monitor and transmitter busy model (busy for 20 cycles after each launch)
    always @(posedge clk) begin
        if (uart_wr) begin
            out_q.push_back(uart_dat);
            out_cyc.push_back(cyc);
            if (prev_wr) consec_err++;
            if (uart_busy) busy_err++;
            if (auto_busy) busy_cnt <= 20;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        prev_wr <= uart_wr;
        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_outputs(input int n, input int limit);
        int k = 0;
        while (out_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        repeat (4) tick();
    endtask

    initial begin
        int n;
        int guard;
        int blen;
        int gap;

        reset = 1'b1; wr = 1'b0; tx_data = 8'h00; busy_man = 1'b0; auto_busy = 1'b0;
`ifdef UART_TXQ_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_uart_wr", uart_wr, 0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        reset = 1'b0;
        tick();

        // Single byte: wr driven after push edge, captured next edge, uart_wr one edge later
        out_q.delete();
        wr = 1'b1; tx_data = 8'h55;
        tick();
        wr = 1'b0;
        chk("lat_c1_uart_wr", uart_wr, 0);
        chk("lat_c1_count", count, 1);
        tick();
        chk("lat_uart_wr", uart_wr, 1);
        chk("lat_uart_dat", uart_dat, 8'h55);
        tick();
        chk("lat_count0", count, 0);
        chk("lat_empty", empty, 1);
        chk("lat_wr_low", uart_wr, 0);
        repeat (3) tick();
        chk("lat_one_out", out_q.size(), 1);

        // Fill to 16 with busy held, then overflow attempts
        out_q.delete(); consec_err = 0; busy_err = 0;
        busy_man = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; tx_data = 8'(i);
            tick();
        end
        wr = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        wr = 1'b1; tx_data = 8'hAA;
        tick();
        wr = 1'b0;
        chk("drop_count", count, 16);
        chk("drop_full", full, 1);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_set", ovf, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        wr = 1'b1; tx_data = 8'hCC; ovf_clr = 1'b1;
        tick();
        wr = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr2", ovf, 0);
`endif

        // Push during LAUNCH while full: pop happens, push is dropped
        busy_man = 1'b0;
        tick();
        chk("full_launch_wr", uart_wr, 1);
        chk("full_launch_dat", uart_dat, 8'h01);
        wr = 1'b1; tx_data = 8'hBB;
        tick();
        wr = 1'b0; busy_man = 1'b1;
        chk("pushpop_count", count, 15);
        chk("pushpop_full", full, 0);
`ifdef UART_TXQ_OVF_EN
        chk("pushpop_ovf", ovf, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
`endif
        busy_man = 1'b0;
        wait_outputs(16, 200);
        chk("fill_out_n", out_q.size(), 16);
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            chk($sformatf("fill_out_%0d", i), out_q[i], 32'(i + 1));
        end
        chk("fill_empty", empty, 1);
        chk("fill_consec", consec_err, 0);

        // Three bytes against a transmitter that stays busy 20 cycles per byte
        out_q.delete(); out_cyc.delete(); consec_err = 0; busy_err = 0;
        auto_busy = 1'b1;
        wr = 1'b1; tx_data = 8'hA1; tick();
        tx_data = 8'hA2; tick();
        tx_data = 8'hA3; tick();
        wr = 1'b0;
        wait_outputs(3, 300);
        chk("busy_out_n", out_q.size(), 3);
        if (out_q.size() == 3) begin
            chk("busy_b0", out_q[0], 8'hA1);
            chk("busy_b1", out_q[1], 8'hA2);
            chk("busy_b2", out_q[2], 8'hA3);
            chk("busy_gap01", out_cyc[1] - out_cyc[0], 22);
            chk("busy_gap12", out_cyc[2] - out_cyc[1], 22);
        end
        chk("busy_viol", busy_err, 0);
        chk("busy_consec", consec_err, 0);
        auto_busy = 1'b0;
        repeat (25) tick();

        // 40 bytes in random bursts, exercising pointer wrap
        out_q.delete(); in_q.delete(); consec_err = 0;
        n = 0; guard = 0;
        while (n < 40 && guard < 2000) begin
            blen = $urandom_range(1, 6);
            gap  = $urandom_range(0, 8);
            for (int b = 0; b < blen; b++) begin
                if (n < 40 && !full) begin
                    wr = 1'b1; tx_data = 8'(n * 37 + 11);
                    in_q.push_back(8'(n * 37 + 11));
                    n++;
                end else begin
                    wr = 1'b0;
                end
                tick();
                guard++;
            end
            wr = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                guard++;
            end
        end
        wait_outputs(40, 400);
        chk("wrap_out_n", out_q.size(), 40);
        for (int i = 0; i < 40 && i < out_q.size(); i++) begin
            chk($sformatf("wrap_out_%0d", i), out_q[i], in_q[i]);
        end
        chk("wrap_consec", consec_err, 0);

        // Reset in the middle of LAUNCH with 5 bytes queued
        out_q.delete();
        busy_man = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; tx_data = 8'(8'hD0 + i);
            tick();
        end
        wr = 1'b0;
        chk("rl_count5", count, 5);
        busy_man = 1'b0;
        tick();
        chk("rl_launch", uart_wr, 1);
        reset = 1'b1;
        #1;
        chk("rl_count0", count, 0);
        chk("rl_empty", empty, 1);
        chk("rl_wr0", uart_wr, 0);
        tick();
        tick();
        reset = 1'b0;
        out_q.delete();
        repeat (10) tick();
        chk("rl_no_out", out_q.size(), 0);
        chk("rl_count_after", count, 0);
        chk("rl_empty_after", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, sets FIFO depth to 2**DEPTH_LOG2 bytes; legal range 1..8.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wr  in  1  push strobe; tx_data is enqueued when wr=1 and full=0.
REQ-006 tx_data  in  8  byte to enqueue.
REQ-007 full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 empty  out  1  FIFO holds 0 bytes.
REQ-009 count  out  DEPTH_LOG2+1  current occupancy.
REQ-010 uart_wr  out  1  one-cycle launch strobe to the downstream transmitter.
REQ-011 uart_dat  out  8  byte presented with uart_wr.
REQ-012 uart_busy  in  1  transmitter busy; it rises the cycle after an accepted uart_wr.
REQ-013 ovf  out  1  sticky overflow flag; present only with UART_TXQ_OVF_EN.
REQ-014 ovf_clr  in  1  clears ovf; present only with UART_TXQ_OVF_EN.

Function
REQ-015 The FIFO shall be circular, with DEPTH_LOG2-bit rd_ptr and wr_ptr that wrap modulo depth, and a separate count register.
REQ-016 Push while full=1 shall be dropped, leaving pointers, count and storage unchanged.
REQ-017 full is evaluated on pre-edge count, so a push in the same cycle as a pop while full shall be dropped.
REQ-018 A push and a pop in the same cycle when not full shall leave count unchanged.
REQ-019 Drain FSM states: IDLE, LAUNCH, HOLD.
REQ-020 IDLE -> LAUNCH when empty=0 and uart_busy=0; otherwise remain in IDLE.
REQ-021 In LAUNCH: uart_wr=1, uart_dat=mem[rd_ptr], rd_ptr advances, count decrements; next state HOLD unconditionally.
REQ-022 HOLD shall last exactly one cycle (covers transmitter busy latency), then return to IDLE; uart_wr shall never assert in two consecutive cycles.
REQ-023 uart_wr shall be 0 in IDLE and HOLD; uart_dat is don't-care when uart_wr=0 but shall be the head byte.
REQ-024 Latency: a push into an empty FIFO with uart_busy=0 shall produce uart_wr exactly 2 cycles after the push edge.
REQ-025 Bytes shall leave the block in push order, with no loss or duplication unless dropped per REQ-016.

Reset
REQ-026 Reset shall clear both pointers and count to 0 and set the FSM to IDLE.
REQ-027 During reset: empty=1, full=0, count=0, uart_wr=0, ovf=0.
REQ-028 Reset asserted mid-LAUNCH shall discard all queued data; no uart_wr shall issue after reset deasserts until a new push.
REQ-029 Storage contents need no reset.

Configuration
REQ-030 With UART_TXQ_OVF_EN defined:
- ovf sets the cycle after any push dropped by REQ-016.
- ovf clears when ovf_clr=1.
- Set wins if both occur in the same cycle.
REQ-031 Without UART_TXQ_OVF_EN, ovf and ovf_clr ports and logic shall be absent; all other behaviour is identical.

Structure
REQ-032 Shared package uart_pkg shall hold the drain-state enum (IDLE/LAUNCH/HOLD) and the DEFAULT_TXQ_DEPTH_LOG2=4 constant.
REQ-033 Storage, pointers and count shall live in sub-module uart_fifo_mem; uart_txq holds the drain FSM and the overflow flag.

Verification
REQ-034 Bench shall cover: reset, push 0x55 with uart_busy=0 -> uart_wr=1 with uart_dat=0x55 exactly 2 cycles later, then count=0, empty=1.
REQ-035 Bench shall cover: push 0x01..0x10 back-to-back (depth 16), uart_busy held 1 -> full=1, count=16; a 17th push 0xAA is dropped; with macro, ovf=1 next cycle.
REQ-036 Bench shall cover: queue 3 bytes, model busy as 1 from the cycle after each uart_wr for 20 cycles -> three uart_wr pulses in order, each ≥2 cycles apart, none while busy=1.
REQ-037 Bench shall cover: full FIFO, push and LAUNCH in the same cycle -> push dropped, count=15.
REQ-038 Bench shall cover wrap-around: 40 bytes pushed and drained in random bursts -> output sequence equals input sequence.
REQ-039 Bench shall cover: reset asserted during LAUNCH with 5 queued bytes -> count=0, empty=1, no uart_wr for 10 cycles after release.
